// File: rtl/packet_parser.sv
// packet_parser: hunts for a sync byte, validates a framed packet and
// releases the buffered payload on a valid/ready stream once verified.
module packet_parser #(
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 2048,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic [8:0]  dataIn,
    input  logic        fifoNE,
    output logic        readEn,
    output logic [7:0]  outData,
    output logic        outValid,
    input  logic        outReady,
    output logic        outLast,
    output logic        frameOk,
    output logic        frameErr,
    output logic [2:0]  errCode,
    output logic [15:0] goodCount,
    output logic [15:0] badCount
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] MAX_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_DRAIN
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    sum_q, sum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ok_q, ok_d;
    logic          err_q, err_d;
    logic [2:0]    code_q, code_d;
    logic [15:0]   good_q, good_d;
    logic [15:0]   bad_q, bad_d;

    logic [7:0]    pay_mem [2**AW];
    logic          pop;
    logic          wr_en;
    logic          abort;
    logic [2:0]    abort_code;
    logic [7:0]    byte_in;
    logic          flag_in;
    logic [7:0]    last_idx;

    assign byte_in  = dataIn[7:0];
    assign flag_in  = dataIn[8];
    assign last_idx = len_q - 8'd1;
    assign pop      = fifoNE && (state_q != S_DRAIN);

    // Pop strobe is held low while reset is asserted.
    assign readEn    = pop && !reset;
    assign outValid  = (state_q == S_DRAIN);
    assign outData   = outValid ? pay_mem[idx_q[AW-1:0]] : 8'h00;
    assign outLast   = outValid && (idx_q == last_idx);
    assign frameOk   = ok_q;
    assign frameErr  = err_q;
    assign errCode   = code_q;
    assign goodCount = good_q;
    assign badCount  = bad_q;

    // Next-state, frame checks, timeout and counter updates.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        tmo_d      = tmo_q;
        ok_d       = 1'b0;
        err_d      = 1'b0;
        code_d     = code_q;
        good_d     = good_q;
        bad_d      = bad_q;
        wr_en      = 1'b0;
        abort      = 1'b0;
        abort_code = 3'd0;

        unique case (state_q)
            S_HUNT: begin
                tmo_d = '0;
                if (pop && !flag_in && byte_in == SYNC_BYTE) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (pop) begin
                    if (flag_in) begin
                        abort      = 1'b1;
                        abort_code = 3'd1;
                    end else if (byte_in == 8'd0 || byte_in > MAX_B) begin
                        abort      = 1'b1;
                        abort_code = 3'd2;
                    end else begin
                        len_d   = byte_in;
                        sum_d   = byte_in;
                        idx_d   = 8'd0;
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (pop) begin
                    if (flag_in) begin
                        abort      = 1'b1;
                        abort_code = 3'd1;
                    end else begin
                        wr_en = 1'b1;
                        sum_d = sum_q + byte_in;
                        idx_d = idx_q + 8'd1;
                        if (idx_q == last_idx) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (pop) begin
                    if (flag_in) begin
                        abort      = 1'b1;
                        abort_code = 3'd1;
                    end else if (byte_in != sum_q) begin
                        abort      = 1'b1;
                        abort_code = 3'd3;
                    end else begin
                        ok_d    = 1'b1;
                        good_d  = (good_q == 16'hFFFF) ? good_q
                                                       : good_q + 16'd1;
                        idx_d   = 8'd0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                tmo_d = '0;
                if (outReady) begin
                    if (idx_q == last_idx) begin
                        state_d = S_HUNT;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_HUNT;
            end
        endcase

        // A pop on the expiry edge keeps the frame alive.
        if (state_q == S_LEN || state_q == S_PAYLOAD ||
            state_q == S_CSUM) begin
            if (pop) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                abort      = 1'b1;
                abort_code = 3'd4;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        if (abort) begin
            err_d   = 1'b1;
            code_d  = abort_code;
            bad_d   = (bad_q == 16'hFFFF) ? bad_q : bad_q + 16'd1;
            tmo_d   = '0;
            state_d = S_HUNT;
        end
    end

    // Control and status registers.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state_q <= S_HUNT;
            len_q   <= 8'd0;
            idx_q   <= 8'd0;
            sum_q   <= 8'd0;
            tmo_q   <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 3'd0;
            good_q  <= 16'd0;
            bad_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            tmo_q   <= tmo_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            code_q  <= code_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
        end
    end

    // Payload buffer; contents are only read after a full verified frame.
    always_ff @(posedge CLK100MHZ) begin
        if (wr_en) begin
            pay_mem[idx_q[AW-1:0]] <= byte_in;
        end
    end

endmodule
